// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding, memory geometry and default frame header
package prog_loader_pkg;
  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;
  localparam logic [7:0] SYNC_DEF = 8'hA5;
  typedef enum logic [1:0] {IDLE, LEN, DATA, CSUM} state_t;
endpackage

// File: rtl/prog_loader_timer.sv
// prog_loader_timer: inter-byte idle counter; clr_i zeroes, en_i counts, expired_o flags the cycle that reaches TIMEOUT
module prog_loader_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int TW = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + TW'(1);
  assign expired_o = TIMEOUT != 0 && en_i && cnt_q == TW'(TIMEOUT - 1);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed host byte stream (in_*) to instruction-memory writes (mem_*), with cpu_hold/cpu_start control and load_ok/load_err/bytes_loaded status
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter logic [DATA_W-1:0] SYNC = SYNC_DEF,
  parameter int TIMEOUT = 255,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              cpu_start_o,
  output logic              load_ok_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   bytes_loaded_o
);
  state_t state_q, state_d;
  logic ready_q, ready_d, we_q, we_d, hold_q, hold_d, start_q, start_d;
  logic ok_q, ok_d, err_q, err_d, acc, expired;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, sum_q, sum_d;
  logic [ADDR_W:0] bl_q, bl_d, cnt_q, cnt_d;
  assign acc = in_valid_i & ready_q;
  prog_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == IDLE || acc),
    .en_i(state_q != IDLE && !acc),
    .expired_o(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= HOLD_AT_RESET;
      start_q <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      bl_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      start_q <= start_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      bl_q    <= bl_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    ready_d = 1'b1;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    start_d = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;
    bl_d    = bl_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (acc && in_data_i == SYNC) begin
        hold_d  = 1'b1;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        bl_d    = '0;
        sum_d   = '0;
        state_d = LEN;
      end
      LEN: if (acc) begin
        if (in_data_i == '0 || 32'(in_data_i) > 32'(2 ** ADDR_W)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = in_data_i[ADDR_W:0];
          state_d = DATA;
        end
      end
      DATA: if (acc) begin
        we_d    = 1'b1;
        addr_d  = bl_q[ADDR_W-1:0];
        wdata_d = in_data_i;
        sum_d   = sum_q + in_data_i;
        bl_d    = bl_q + (ADDR_W + 1)'(1);
        state_d = bl_d == cnt_q ? CSUM : DATA;
      end
      CSUM: if (acc) begin
        ok_d    = in_data_i == sum_q;
        err_d   = in_data_i != sum_q;
        hold_d  = in_data_i != sum_q;
        start_d = in_data_i == sum_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (expired) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end
  assign in_ready_o     = ready_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign cpu_hold_o     = hold_q;
  assign cpu_start_o    = start_q;
  assign load_ok_o      = ok_q;
  assign load_err_o     = err_q;
  assign bytes_loaded_o = bl_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random and directed frames against a frame-level reference model, two DUTs (TIMEOUT 255 and 0)
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [7:0] in_data;
  logic rdy[2], we[2], hold[2], start[2], ok[2], er[2];
  logic [3:0] addr[2];
  logic [7:0] wd[2];
  logic [4:0] bl[2];
  int vec = 0, err = 0, starts = 0;
  logic [11:0] wq[$], eq[$];
  typedef struct {
    int ph, n, sum, tmr, addr, wd, bl;
    bit rdy, we, hold, start, ok, er;
  } mdl_t;
  mdl_t m[2];
  int to_val[2] = '{255, 0};
  always #5 clk = ~clk;
  prog_loader #(.TIMEOUT(255)) u0 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy[0]),
    .mem_we_o(we[0]), .mem_addr_o(addr[0]), .mem_wdata_o(wd[0]), .cpu_hold_o(hold[0]),
    .cpu_start_o(start[0]), .load_ok_o(ok[0]), .load_err_o(er[0]), .bytes_loaded_o(bl[0])
  );
  prog_loader #(.TIMEOUT(0)) u1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy[1]),
    .mem_we_o(we[1]), .mem_addr_o(addr[1]), .mem_wdata_o(wd[1]), .cpu_hold_o(hold[1]),
    .cpu_start_o(start[1]), .load_ok_o(ok[1]), .load_err_o(er[1]), .bytes_loaded_o(bl[1])
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic mreset(input int k);
    m[k] = '{ph: 0, n: 0, sum: 0, tmr: 0, addr: 0, wd: 0, bl: 0,
             rdy: 0, we: 0, hold: 1, start: 0, ok: 0, er: 0};
  endtask
  task automatic step(input int k);
    bit acc;
    int b;
    acc = in_valid && m[k].rdy;
    b = int'(in_data);
    m[k].rdy = 1;
    m[k].we = 0;
    m[k].start = 0;
    if (m[k].ph == 0) begin
      if (acc && b == 'hA5) begin
        m[k].hold = 1; m[k].ok = 0; m[k].er = 0; m[k].bl = 0; m[k].sum = 0; m[k].tmr = 0; m[k].ph = 1;
      end
    end else begin
      m[k].tmr = acc ? 0 : m[k].tmr + 1;
      if (!acc && to_val[k] != 0 && m[k].tmr == to_val[k]) begin
        m[k].er = 1; m[k].ph = 0;
      end else if (acc && m[k].ph == 1) begin
        if (b == 0 || b > 16) begin
          m[k].er = 1; m[k].ph = 0;
        end else begin
          m[k].n = b; m[k].ph = 2;
        end
      end else if (acc && m[k].ph == 2) begin
        m[k].we = 1; m[k].addr = m[k].bl; m[k].wd = b;
        m[k].sum = (m[k].sum + b) % 256;
        m[k].bl++;
        if (m[k].bl == m[k].n) m[k].ph = 3;
      end else if (acc && m[k].ph == 3) begin
        if (b == m[k].sum) begin
          m[k].ok = 1; m[k].hold = 0; m[k].start = 1;
        end else m[k].er = 1;
        m[k].ph = 0;
      end
    end
  endtask
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) mreset(k);
      else step(k);
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.in_ready", k), 32'(rdy[k]), 32'(m[k].rdy));
      chk($sformatf("u%0d.mem_we", k), 32'(we[k]), 32'(m[k].we));
      if (m[k].we) begin
        chk($sformatf("u%0d.mem_addr", k), 32'(addr[k]), m[k].addr);
        chk($sformatf("u%0d.mem_wdata", k), 32'(wd[k]), m[k].wd);
      end
      chk($sformatf("u%0d.cpu_hold", k), 32'(hold[k]), 32'(m[k].hold));
      chk($sformatf("u%0d.cpu_start", k), 32'(start[k]), 32'(m[k].start));
      chk($sformatf("u%0d.load_ok", k), 32'(ok[k]), 32'(m[k].ok));
      chk($sformatf("u%0d.load_err", k), 32'(er[k]), 32'(m[k].er));
      chk($sformatf("u%0d.bytes_loaded", k), 32'(bl[k]), m[k].bl);
    end
    if (we[0] === 1'b1) wq.push_back({addr[0], wd[0]});
    if (start[0] === 1'b1) starts++;
  end
  task automatic put(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
  endtask
  task automatic wr_chk(input string nm);
    chk({nm, ".nwrites"}, wq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < wq.size(); i++)
      chk($sformatf("%s.write%0d", nm, i), 32'(wq[i]), 32'(eq[i]));
  endtask
  task automatic rand_frame();
    int n, s;
    logic [7:0] b;
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      put(b == 8'hA5 ? 8'h00 : b);
    end
    n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(1, 16);
    put(8'hA5);
    put(8'(n));
    s = 0;
    for (int i = 0; i < n && i < 16; i++) begin
      b = 8'($urandom);
      s += int'(b);
      put(b);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end
    put($urandom_range(0, 3) == 0 ? 8'(s + 1) : 8'(s));
    idle($urandom_range(0, 2));
  endtask
  initial begin
    in_valid = 1'b0;
    in_data = 8'h00;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst.in_ready", 32'(rdy[0]), 0);
    chk("rst.cpu_hold", 32'(hold[0]), 1);
    chk("rst.bytes_loaded", 32'(bl[0]), 0);
    do_reset();
    wq = {};
    starts = 0;
    put(8'hA5); put(8'h03); put(8'h70); put(8'h61); put(8'h4F); put(8'h20);
    chk("good.start_now", 32'(start[0]), 1);
    idle(2);
    eq = {12'h070, 12'h161, 12'h24F};
    wr_chk("good");
    chk("good.load_ok", 32'(ok[0]), 1);
    chk("good.cpu_hold", 32'(hold[0]), 0);
    chk("good.start_count", starts, 1);
    chk("good.bytes_loaded", 32'(bl[0]), 3);
    wq = {};
    starts = 0;
    put(8'hA5);
    chk("resync.cpu_hold", 32'(hold[0]), 1);
    put(8'h02); put(8'h10); put(8'h20); put(8'h31);
    idle(2);
    eq = {12'h010, 12'h120};
    wr_chk("badsum");
    chk("badsum.load_err", 32'(er[0]), 1);
    chk("badsum.cpu_hold", 32'(hold[0]), 1);
    chk("badsum.starts", starts, 0);
    wq = {};
    put(8'hA5); put(8'h00); idle(2);
    chk("n0.load_err", 32'(er[0]), 1);
    chk("n0.nwrites", wq.size(), 0);
    put(8'hA5); put(8'h11); idle(2);
    chk("n17.load_err", 32'(er[0]), 1);
    wq = {};
    eq = {};
    put(8'hA5); put(8'h10);
    for (int i = 0; i < 16; i++) begin
      put(8'(i * 7 + 3));
      eq.push_back({4'(i), 8'(i * 7 + 3)});
    end
    put(8'h78);
    idle(2);
    wr_chk("n16");
    chk("n16.load_ok", 32'(ok[0]), 1);
    chk("n16.bytes_loaded", 32'(bl[0]), 16);
    wq = {};
    put(8'h00); put(8'hFF); put(8'hA4); put(8'hA5); put(8'h01); put(8'hF0); put(8'hF0);
    idle(2);
    eq = {12'h0F0};
    wr_chk("garbage");
    chk("garbage.load_ok", 32'(ok[0]), 1);
    wq = {};
    put(8'hA5); put(8'h02); put(8'h11);
    idle(254);
    chk("to.before", 32'(er[0]), 0);
    idle(1);
    chk("to.at255", 32'(er[0]), 1);
    chk("to0.no_err", 32'(er[1]), 0);
    put(8'h22); put(8'h33);
    idle(2);
    eq = {12'h011};
    wr_chk("to.ignored");
    chk("to0.load_ok", 32'(ok[1]), 1);
    put(8'hA5); put(8'h04); put(8'h01); put(8'h02);
    #2 rst = 1'b1;
    #1;
    chk("midrst.mem_we", 32'(we[0]), 0);
    chk("midrst.in_ready", 32'(rdy[0]), 0);
    chk("midrst.cpu_hold", 32'(hold[0]), 1);
    chk("midrst.bytes_loaded", 32'(bl[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    put(8'hA5); put(8'h02); put(8'h05); put(8'h06); put(8'h0B);
    idle(1);
    chk("reload.load_ok", 32'(ok[0]), 1);
    chk("reload.cpu_hold", 32'(hold[0]), 0);
    put(8'hA5);
    chk("reload.rehold", 32'(hold[0]), 1);
    put(8'h01); put(8'h09); put(8'h09);
    for (int f = 0; f < 40; f++) rand_frame();
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
